// File: rtl/counter_pkg.sv
// Shared encodings for the up/down COUNTER and the sequencer that drives it.
// Direction constants match the COUNTER CONTROL input (1 = up).
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN_UP   = 2'b01,
        RUN_DOWN = 2'b10
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // The reserved encoding behaves exactly like a plain up sweep.
    function automatic mode_e normalize_mode(input logic [1:0] raw);
        mode_e m;
        m = mode_e'(raw);
        if (m == MODE_RSVD) begin
            m = MODE_UP;
        end
        return m;
    endfunction

endpackage

// File: rtl/COUNTER.sv
// Scalable registered up/down counter, wrapping modulo 2^WIDTH.
// Holds its value whenever ENABLE is low.
module COUNTER
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             CONTROL,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            COUNT <= '0;
        end else if (ENABLE) begin
            if (CONTROL == DIR_UP) begin
                COUNT <= COUNT + WIDTH'(1);
            end else begin
                COUNT <= COUNT - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven sweep sequencer: drives ENABLE/CONTROL of one COUNTER and
// stops it exactly on the commanded value, then pulses DONE.
module count_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_MODE,
    input  logic [WIDTH-1:0]  CMD_TARGET,
    input  logic [REPS_W-1:0] CMD_REPS,
    input  logic              ABORT,
    input  logic [WIDTH-1:0]  COUNT_IN,
    output logic              ENABLE_OUT,
    output logic              CONTROL_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORTED
);

    state_e             state;
    state_e             next_state;
    mode_e              mode_q;
    mode_e              cmd_mode;
    logic [WIDTH-1:0]   target_q;
    logic [WIDTH-1:0]   base_q;
    logic [WIDTH-1:0]   target_leg;
    logic [REPS_W-1:0]  reps_q;
    logic               armed_q;
    logic               running;
    logic               at_target;
    logic               accept;
    logic               last_rep;
    logic               rep_step;
    logic               done_next;
    logic               aborted_next;

    assign cmd_mode   = normalize_mode(CMD_MODE);
    assign running    = (state != IDLE);
    assign target_leg = (state == RUN_DOWN && mode_q == MODE_TRI) ? base_q : target_q;
    assign at_target  = (COUNT_IN == target_leg);
    assign last_rep   = (reps_q == REPS_W'(1));

    // armed_q keeps READY low until the first edge after reset release.
    assign CMD_READY   = RESET && armed_q && (state == IDLE) && !ABORT;
    assign accept      = CMD_VALID && CMD_READY;
    assign ENABLE_OUT  = running && !at_target && !ABORT;
    assign CONTROL_OUT = (state == RUN_DOWN) ? DIR_DOWN : DIR_UP;
    assign BUSY        = running;

    assign rep_step = (state == RUN_DOWN) && !ABORT && at_target &&
                      (mode_q == MODE_TRI) && !last_rep;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            armed_q <= 1'b0;
            DONE    <= 1'b0;
            ABORTED <= 1'b0;
        end else begin
            state   <= next_state;
            armed_q <= 1'b1;
            DONE    <= done_next;
            ABORTED <= aborted_next;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            mode_q   <= MODE_UP;
            target_q <= '0;
            base_q   <= '0;
            reps_q   <= REPS_W'(1);
        end else if (accept) begin
            mode_q   <= cmd_mode;
            target_q <= CMD_TARGET;
            base_q   <= COUNT_IN;
            reps_q   <= (CMD_REPS == '0) ? REPS_W'(1) : CMD_REPS;
        end else if (rep_step) begin
            reps_q <= reps_q - REPS_W'(1);
        end
    end

    // Abort wins over a leg end seen on the same edge.
    always_comb begin
        next_state   = state;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (cmd_mode == MODE_DOWN) ? RUN_DOWN : RUN_UP;
                end
            end
            RUN_UP: begin
                if (ABORT) begin
                    next_state   = IDLE;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (at_target) begin
                    if (mode_q == MODE_TRI) begin
                        next_state = RUN_DOWN;
                    end else begin
                        next_state = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            RUN_DOWN: begin
                if (ABORT) begin
                    next_state   = IDLE;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (at_target) begin
                    if (mode_q == MODE_TRI && !last_rep) begin
                        next_state = RUN_UP;
                    end else begin
                        next_state = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Command-driven sequencer for the scalable up/down `COUNTER`. It accepts sweep commands over a valid/ready handshake and drives the counter's enable and direction inputs. It watches the counter's `COUNT` output so the counter stops exactly on the commanded value, then signals completion. It sits between the control logic and one `COUNTER` instance and is the only driver of that instance's `ENABLE` and `CONTROL`.

## Interface
- `WIDTH`, 4: counter width; must equal the attached `COUNTER` width.
- `REPS_W`, 4: width of the triangle repeat count.
- `CLOCK`  in  1  single clock, rising edge, shared with `COUNTER`.
- `RESET`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  command accepted on an edge where `CMD_VALID && CMD_READY`.
- `CMD_MODE`  in  2  00 = up-to-target, 01 = down-to-target, 10 = triangle, 11 = reserved (accepted, treated as 00).
- `CMD_TARGET`  in  WIDTH  stop value (apex for triangle).
- `CMD_REPS`  in  REPS_W  triangle repetitions; 0 is treated as 1; ignored in other modes.
- `ABORT`  in  1  terminate the current command.
- `COUNT_IN`  in  WIDTH  the counter's `COUNT`.
- `ENABLE_OUT`  out  1  to `COUNTER` `ENABLE`.
- `CONTROL_OUT`  out  1  to `COUNTER` `CONTROL`; 1 = up, 0 = down.
- `BUSY`  out  1  a command is executing.
- `DONE`  out  1  one-cycle completion pulse.
- `ABORTED`  out  1  qualifies `DONE`; 1 = ended by `ABORT`.

## Operation
- States:
  - IDLE → RUN_UP (mode 00/11/10) or RUN_DOWN (mode 01) on command accept.
  - RUN_UP and RUN_DOWN → IDLE on leg/command end or `ABORT`.
- On accept, latch `CMD_TARGET`, mode, and reps (0→1). Latch base = `COUNT_IN`.
- `ENABLE_OUT` = in RUN state && `COUNT_IN != target_leg` && `!ABORT` (combinational).
  - This gives no overshoot: the counter is registered and stops holding the target.
- `target_leg`:
  - Latched target in RUN_UP.
  - In RUN_DOWN, the latched target for mode 01, or base for triangle.
- `CONTROL_OUT` = 0 in RUN_DOWN, otherwise 1.
- Counting wraps modulo 2^WIDTH. Distance d = (target − start) mod 2^WIDTH for up, and (start − target) mod 2^WIDTH for down.
- Leg end is a RUN edge with `COUNT_IN == target_leg`:
  - Modes 00/01: go to IDLE and pulse `DONE`.
  - Triangle, RUN_UP: go to RUN_DOWN.
  - Triangle, RUN_DOWN: decrement reps. If reps was 1, go to IDLE with `DONE`; otherwise go to RUN_UP.
- Triangle with target == base: each leg is zero-length, one cycle per leg.
- `ABORT` in RUN:
  - `ENABLE_OUT` drops in the same cycle and the counter holds.
  - Next edge goes to IDLE with `DONE=1` and `ABORTED=1`.
- `ABORT` in IDLE forces `CMD_READY=0`. `ABORT` has priority over a simultaneous `CMD_VALID`.
- The sequencer never resets the counter. The counter's position is whatever `COUNT_IN` reads at accept.

## Timing
- `CMD_READY` = `RESET` high && IDLE && `!ABORT` (combinational).
  - It is high during the `DONE` cycle, so back-to-back commands lose no cycle.
- Accept at edge E0: RUN occupies the cycles after E0.
  - For a single leg of distance d, `ENABLE_OUT` is high for exactly d cycles.
  - This is followed by one compare cycle.
  - `DONE` is high for the one cycle after edge E0+d+1.
- Triangle of R reps: `DONE` follows edge E0 + 2·d·R + 2·R, where d = (target − base) mod 2^WIDTH.
- `BUSY` is high from E0 until the edge that raises `DONE`. `BUSY` and `DONE` are never both high.
- `DONE` and `ABORTED` are registered. All other outputs are combinational from state and inputs.
- Reset values, applied asynchronously while `RESET` is low and holding until the first edge after release:
  - state IDLE, `ENABLE_OUT=0`, `CONTROL_OUT=1`, `BUSY=0`, `DONE=0`, `ABORTED=0`, `CMD_READY=0`.
- Reset mid-command discards the command. No `DONE` is generated.

## Structure
- Shared package `counter_pkg`:
  - Mode encodings (MODE_UP, MODE_DOWN, MODE_TRI).
  - State encoding.
  - Direction constants DIR_UP=1 and DIR_DOWN=0, shared with `COUNTER`.
- No sub-module. This is one FSM plus target, base, and reps registers.
- The bench instantiates `count_sequencer` wired to a real `COUNTER` instance.

## Test plan
All scenarios use WIDTH=4.
- Up: `COUNT_IN`=0, mode 00, target 5 → `ENABLE_OUT` high 5 cycles, `COUNT` 0→5 and holds at 5. `DONE=1`/`ABORTED=0` after edge E0+6.
- Down with wrap: `COUNT`=2, mode 01, target 14 → `CONTROL_OUT=0` for the whole RUN, `COUNT` goes 2,1,0,15,14, 4 enabled cycles, `DONE` after E0+5.
- Triangle: `COUNT`=3, mode 10, target 6, reps 2 → `COUNT` goes 3,4,5,6,5,4,3,4,5,6,5,4,3, 12 enabled cycles, `DONE` after E0+16, final `COUNT`=3.
- Zero distance: `COUNT`=7, mode 00, target 7 → `ENABLE_OUT` never high, `DONE` after E0+1. A second command on the `DONE` cycle is accepted immediately.
- Abort: up 0→12, `ABORT` asserted when `COUNT`=9 → `ENABLE_OUT` low in that cycle, `COUNT` holds at 9, `DONE=1`/`ABORTED=1` next cycle. `CMD_VALID` together with `ABORT` in IDLE is not accepted.
- Reset mid-triangle: `RESET` low asynchronously → `ENABLE_OUT=0`, `CONTROL_OUT=1`, `BUSY=0` immediately, no `DONE`. `CMD_READY=1` only after the first edge following release.
